// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: EX stage with an iterative multiply/divide unit, HI/LO
// registers and a registered EX/MEM output.
// Optional build macro: EXEC_MDU_EARLY_OUT_EN (multiplies finish as soon as
// the remaining multiplier magnitude is exhausted).
module execute_stage_mdu #(
    parameter int DWIDTH       = 32,
    parameter int OPCODE_WIDTH = 6,
    parameter int REG_WIDTH    = 5
) (
    input  logic                    ep_i_clk,
    input  logic                    ep_i_rst,
    input  logic                    ep_i_ce,
    input  logic                    ep_i_flush,
    input  logic [2:0]              ep_i_mdu_op,
    input  logic [DWIDTH-1:0]       ep_i_data_rs,
    input  logic [DWIDTH-1:0]       ep_i_data_rt,
    input  logic [DWIDTH-1:0]       ep_i_alu_value,
    input  logic [OPCODE_WIDTH-1:0] ep_i_opcode,
    input  logic [REG_WIDTH-1:0]    ep_i_rd,
    output logic                    ep_o_ce,
    output logic [DWIDTH-1:0]       ep_o_alu_value,
    output logic [OPCODE_WIDTH-1:0] ep_o_opcode,
    output logic [REG_WIDTH-1:0]    ep_o_rd,
    output logic                    ep_o_stall,
    output logic                    ep_o_busy
);
    localparam int CNT_W = $clog2(DWIDTH + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MFHI  = 3'd5,
        OP_MFLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e  state, state_nxt;
    mdu_op_e op;

    logic              live, is_muldiv, is_mdu, is_signed, start, last;
    logic              rs_neg, rt_neg;
    logic [DWIDTH-1:0] rs_mag, rt_mag;

    // MDU working state
    logic [CNT_W-1:0]    cnt;
    logic                is_div, neg_q, neg_r, div_zero;
    logic [DWIDTH-1:0]   rs_keep, shreg, rem, dvsr, hi, lo;
    logic [2*DWIDTH-1:0] prod, mcand;

    // Per-step datapath
    logic [2*DWIDTH-1:0] prod_nxt, prod_fix;
    logic [DWIDTH:0]     rem_sh, diff;
    logic [DWIDTH-1:0]   quo_nxt, rem_nxt, hi_fin, lo_fin;

    // Decode the presented instruction and derive operand magnitudes
    always_comb begin
        op        = mdu_op_e'(ep_i_mdu_op);
        live      = ep_i_ce & ~ep_i_flush;
        is_muldiv = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        is_mdu    = is_muldiv | (op == OP_MFHI) | (op == OP_MFLO);
        is_signed = (op == OP_MULT) | (op == OP_DIV);
        rs_neg    = is_signed & ep_i_data_rs[DWIDTH-1];
        rt_neg    = is_signed & ep_i_data_rt[DWIDTH-1];
        rs_mag    = rs_neg ? -ep_i_data_rs : ep_i_data_rs;
        rt_mag    = rt_neg ? -ep_i_data_rt : ep_i_data_rt;
    end

    assign ep_o_busy  = (state == ST_BUSY);
    assign ep_o_stall = live & is_mdu & ep_o_busy;
    assign start      = live & is_muldiv & (state == ST_IDLE);

`ifdef EXEC_MDU_EARLY_OUT_EN
    // shreg holds the not-yet-consumed multiplier bits; once only bit 0 is
    // left, this step finishes the product.
    assign last = (cnt == CNT_W'(1)) | (~is_div & (shreg[DWIDTH-1:1] == '0));
`else
    assign last = (cnt == CNT_W'(1));
`endif

    // One radix-2 step of shift-add multiply / restoring divide, plus the
    // sign-corrected final HI/LO for the step that completes the op
    always_comb begin
        prod_nxt = shreg[0] ? (prod + mcand) : prod;
        prod_fix = neg_q ? -prod_nxt : prod_nxt;
        rem_sh   = {rem, shreg[DWIDTH-1]};
        diff     = rem_sh - {1'b0, dvsr};
        quo_nxt  = {shreg[DWIDTH-2:0], ~diff[DWIDTH]};
        rem_nxt  = diff[DWIDTH] ? rem_sh[DWIDTH-1:0] : diff[DWIDTH-1:0];
        hi_fin   = prod_fix[2*DWIDTH-1:DWIDTH];
        lo_fin   = prod_fix[DWIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                lo_fin = '1;
                hi_fin = rs_keep;
            end else begin
                lo_fin = neg_q ? -quo_nxt : quo_nxt;
                hi_fin = neg_r ? -rem_nxt : rem_nxt;
            end
        end
    end

    // FSM state register
    always_ff @(posedge ep_i_clk) begin
        if (ep_i_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_BUSY;
            ST_BUSY: if (last)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // MDU operand load, iteration and HI/LO write-back
    always_ff @(posedge ep_i_clk) begin
        if (ep_i_rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            rs_keep  <= '0;
            shreg    <= '0;
            rem      <= '0;
            dvsr     <= '0;
            prod     <= '0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (start) begin
            cnt      <= CNT_W'(DWIDTH);
            is_div   <= (op == OP_DIV) | (op == OP_DIVU);
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (ep_i_data_rt == '0);
            rs_keep  <= ep_i_data_rs;
            shreg    <= ((op == OP_DIV) | (op == OP_DIVU)) ? rs_mag : rt_mag;
            rem      <= '0;
            dvsr     <= rt_mag;
            prod     <= '0;
            mcand    <= {{DWIDTH{1'b0}}, rs_mag};
        end else if (state == ST_BUSY) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div) begin
                shreg <= quo_nxt;
                rem   <= rem_nxt;
            end else begin
                prod  <= prod_nxt;
                mcand <= mcand << 1;
                shreg <= shreg >> 1;
            end
            if (last) begin
                hi <= hi_fin;
                lo <= lo_fin;
            end
        end
    end

    // EX/MEM output register; stalled, flushed or idle slots become bubbles
    always_ff @(posedge ep_i_clk) begin
        if (ep_i_rst || ep_o_stall || !live) begin
            ep_o_ce        <= 1'b0;
            ep_o_alu_value <= '0;
            ep_o_opcode    <= '0;
            ep_o_rd        <= '0;
        end else begin
            ep_o_ce     <= 1'b1;
            ep_o_opcode <= ep_i_opcode;
            ep_o_rd     <= ep_i_rd;
            case (op)
                OP_NONE, OP_RSVD: ep_o_alu_value <= ep_i_alu_value;
                OP_MFHI:          ep_o_alu_value <= hi;
                OP_MFLO:          ep_o_alu_value <= lo;
                default:          ep_o_alu_value <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb_execute_stage_mdu: scoreboard bench for execute_stage_mdu (DWIDTH=32).
// Honours EXEC_MDU_EARLY_OUT_EN for expected multiply latency.
`timescale 1ns/1ps
module tb_execute_stage_mdu;
    localparam int DW = 32;
    localparam int OW = 6;
    localparam int RW = 5;

    localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, MFHI = 3'd5, MFLO = 3'd6, RSVD = 3'd7;

    typedef struct packed {
        logic          ce;
        logic [DW-1:0] val;
        logic [OW-1:0] opc;
        logic [RW-1:0] rd;
    } out_t;

    logic          clk = 1'b0;
    logic          rst, ce, flush;
    logic [2:0]    op;
    logic [DW-1:0] rs, rt, alu;
    logic [OW-1:0] opc;
    logic [RW-1:0] rd;
    logic          o_ce, o_stall, o_busy;
    logic [DW-1:0] o_val;
    logic [OW-1:0] o_opc;
    logic [RW-1:0] o_rd;

    out_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] model_hi = '0;
    logic [DW-1:0] model_lo = '0;

    execute_stage_mdu #(
        .DWIDTH(DW),
        .OPCODE_WIDTH(OW),
        .REG_WIDTH(RW)
    ) dut (
        .ep_i_clk(clk),
        .ep_i_rst(rst),
        .ep_i_ce(ce),
        .ep_i_flush(flush),
        .ep_i_mdu_op(op),
        .ep_i_data_rs(rs),
        .ep_i_data_rt(rt),
        .ep_i_alu_value(alu),
        .ep_i_opcode(opc),
        .ep_i_rd(rd),
        .ep_o_ce(o_ce),
        .ep_o_alu_value(o_val),
        .ep_o_opcode(o_opc),
        .ep_o_rd(o_rd),
        .ep_o_stall(o_stall),
        .ep_o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic c, input logic f, input logic [2:0] o,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] v, input logic [OW-1:0] oc,
                         input logic [RW-1:0] r);
        ce = c; flush = f; op = o; rs = a; rt = b; alu = v; opc = oc; rd = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference HI/LO from plain integer arithmetic
    function automatic void ref_mdu(input logic [2:0] o, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b,
                                    output logic [DW-1:0] h, output logic [DW-1:0] l);
        longint          sp;
        longint unsigned up;
        int              sa, sd;
        h = '0;
        l = '0;
        case (o)
            MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {h, l} = sp;
            end
            MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {h, l} = up;
            end
            DIVU: begin
                if (b == 0) begin l = '1; h = a; end
                else begin l = a / b; h = a % b; end
            end
            DIV: begin
                if (b == 0) begin l = '1; h = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = '0; end
                else begin
                    sa = $signed(a);
                    sd = $signed(b);
                    l = sa / sd;
                    h = sa % sd;
                end
            end
            default: ;
        endcase
    endfunction

    // Expected number of BUSY cycles
    function automatic int exp_lat(input logic [2:0] o, input logic [DW-1:0] b);
        logic [DW-1:0] m;
        int            n;
        m = (o == MULT && b[DW-1]) ? -b : b;
        n = 1;
        while (m > 1) begin
            m = m >> 1;
            n++;
        end
`ifdef EXEC_MDU_EARLY_OUT_EN
        if (o == MULT || o == MULTU) return n;
`endif
        return 32;
    endfunction

    task automatic test_reset();
        out_t got, exp;
        rst = 1'b1;
        drive(1'b1, 1'b0, NONE, 32'h1, 32'h2, 32'hDEAD_BEEF, 6'h3F, 5'h1F);
        sb.push_back(out_t'('0));
        tick();
        got = {o_ce, o_val, o_opc, o_rd};
        exp = sb.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected %h", got, exp);
        end
        n_tests++;
        if ({o_stall, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_stall_busy: got %b expected 00", {o_stall, o_busy});
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_path();
        logic          tc[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic          tf[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]    to[6] = '{NONE, RSVD, NONE, NONE, MFHI, MFLO};
        logic [DW-1:0] tv[6] = '{32'h0000_1111, 32'hFFFF_FFFF, 32'h5555, 32'h6666, 32'h777, 32'h888};
        out_t          got, exp;
        for (int i = 0; i < 6; i++) begin
            drive(tc[i], tf[i], to[i], 32'hFFFF_FFFF, 32'h3, tv[i], OW'(i + 8), RW'(i + 20));
            #1;
            if (!tc[i] || tf[i])  exp = out_t'('0);
            else if (to[i] == MFHI) exp = {1'b1, model_hi, OW'(i + 8), RW'(i + 20)};
            else if (to[i] == MFLO) exp = {1'b1, model_lo, OW'(i + 8), RW'(i + 20)};
            else                    exp = {1'b1, tv[i], OW'(i + 8), RW'(i + 20)};
            n_tests++;
            if (o_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_stall[%0d]: got %b expected 0", i, o_stall);
            end
            sb.push_back(exp);
            tick();
            got = {o_ce, o_val, o_opc, o_rd};
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL alu_out[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    // Issue one MULT*/DIV*, then MFLO (stalled until done), then MFHI
    task automatic test_mdu_op(input logic [2:0] o, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [DW-1:0] eh,
                               input logic [DW-1:0] el, input string name);
        out_t got, exp;
        int   lat, n, phase;
        logic xs;
        lat   = exp_lat(o, b);
        n     = 0;
        phase = 0;
        for (int cyc = 0; cyc < 80 && phase < 3; cyc++) begin
            xs = 1'b0;
            if (phase == 0) begin
                drive(1'b1, 1'b0, o, a, b, 32'hA5A5_A5A5, 6'h11, 5'd9);
                exp = {1'b1, 32'h0, 6'h11, 5'd9};
            end else if (phase == 1) begin
                drive(1'b1, 1'b0, MFLO, 32'h0, 32'h0, 32'h5A5A_5A5A, 6'h12, 5'd10);
                xs = (n < lat);
                if (xs) exp = out_t'('0);
                else    exp = {1'b1, el, 6'h12, 5'd10};
            end else begin
                drive(1'b1, 1'b0, MFHI, 32'h0, 32'h0, 32'h5A5A_5A5A, 6'h13, 5'd11);
                exp = {1'b1, eh, 6'h13, 5'd11};
            end
            #1;
            n_tests++;
            if ({o_stall, o_busy} !== {xs, xs}) begin
                n_fail++;
                $display("FAIL %s stall_busy phase%0d n=%0d: got %b expected %b",
                         name, phase, n, {o_stall, o_busy}, {xs, xs});
            end
            sb.push_back(exp);
            tick();
            got = {o_ce, o_val, o_opc, o_rd};
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s out phase%0d n=%0d: got %h expected %h", name, phase, n, got, exp);
            end
            if (phase == 1 && xs) n++;
            else phase++;
        end
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic test_busy_passthrough();
        out_t got, exp;
        logic xs, xb;
        for (int c = 0; c <= 34; c++) begin
            xb = (c >= 1 && c <= 32);
            xs = 1'b0;
            if (c == 0) begin
                drive(1'b1, 1'b0, DIVU, 32'd100, 32'd7, 32'h0, 6'h21, 5'd1);
                exp = {1'b1, 32'h0, 6'h21, 5'd1};
            end else if (c == 1) begin
                drive(1'b1, 1'b0, NONE, 32'h9, 32'h9, 32'h1234, 6'h22, 5'd2);
                exp = {1'b1, 32'h1234, 6'h22, 5'd2};
            end else if (c == 2) begin
                drive(1'b1, 1'b1, NONE, 32'h9, 32'h9, 32'h1234, 6'h22, 5'd2);
                exp = out_t'('0);
            end else if (c == 3) begin
                drive(1'b1, 1'b0, RSVD, 32'h9, 32'h9, 32'h5678, 6'h23, 5'd3);
                exp = {1'b1, 32'h5678, 6'h23, 5'd3};
            end else if (c == 4) begin
                drive(1'b0, 1'b0, MFLO, 32'h0, 32'h0, 32'h0, 6'h24, 5'd4);
                exp = out_t'('0);
            end else if (c <= 33) begin
                drive(1'b1, 1'b0, MFLO, 32'h0, 32'h0, 32'h0, 6'h24, 5'd4);
                xs = (c <= 32);
                if (xs) exp = out_t'('0);
                else    exp = {1'b1, 32'h0000_000E, 6'h24, 5'd4};
            end else begin
                drive(1'b1, 1'b0, MFHI, 32'h0, 32'h0, 32'h0, 6'h25, 5'd5);
                exp = {1'b1, 32'h0000_0002, 6'h25, 5'd5};
            end
            #1;
            n_tests++;
            if ({o_stall, o_busy} !== {xs, xb}) begin
                n_fail++;
                $display("FAIL busy_pass stall_busy c=%0d: got %b expected %b", c, {o_stall, o_busy}, {xs, xb});
            end
            sb.push_back(exp);
            tick();
            got = {o_ce, o_val, o_opc, o_rd};
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL busy_pass out c=%0d: got %h expected %h", c, got, exp);
            end
        end
        model_hi = 32'h2;
        model_lo = 32'hE;
    endtask

    task automatic test_flush_no_start();
        out_t got, exp;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin drive(1'b1, 1'b1, MULT, 32'h5, 32'h5, 32'h0, 6'h31, 5'd6); exp = out_t'('0); end
                1: begin drive(1'b0, 1'b0, DIV, 32'h9, 32'h3, 32'h0, 6'h32, 5'd7); exp = out_t'('0); end
                2: begin drive(1'b1, 1'b0, MFHI, 32'h0, 32'h0, 32'h0, 6'h33, 5'd8); exp = {1'b1, model_hi, 6'h33, 5'd8}; end
                default: begin drive(1'b1, 1'b0, MFLO, 32'h0, 32'h0, 32'h0, 6'h34, 5'd9); exp = {1'b1, model_lo, 6'h34, 5'd9}; end
            endcase
            #1;
            n_tests++;
            if ({o_stall, o_busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL no_start stall_busy c=%0d: got %b expected 00", c, {o_stall, o_busy});
            end
            sb.push_back(exp);
            tick();
            got = {o_ce, o_val, o_opc, o_rd};
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL no_start out c=%0d: got %h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        out_t got, exp;
        logic xb;
        for (int c = 0; c <= 12; c++) begin
            xb = (c >= 1 && c <= 10);
            if (c == 0) begin
                drive(1'b1, 1'b0, MULTU, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 6'h2A, 5'd12);
                exp = {1'b1, 32'h0, 6'h2A, 5'd12};
            end else if (c <= 9) begin
                drive(1'b0, 1'b0, NONE, 32'h0, 32'h0, 32'h0, 6'h0, 5'd0);
                exp = out_t'('0);
            end else if (c == 10) begin
                rst = 1'b1;
                drive(1'b1, 1'b0, NONE, 32'h0, 32'h0, 32'hFFFF, 6'h2B, 5'd13);
                exp = out_t'('0);
            end else if (c == 11) begin
                rst = 1'b0;
                drive(1'b1, 1'b0, MFHI, 32'h0, 32'h0, 32'h0, 6'h2C, 5'd14);
                exp = {1'b1, 32'h0, 6'h2C, 5'd14};
            end else begin
                drive(1'b1, 1'b0, MFLO, 32'h0, 32'h0, 32'h0, 6'h2D, 5'd15);
                exp = {1'b1, 32'h0, 6'h2D, 5'd15};
            end
            #1;
            n_tests++;
            if ({o_stall, o_busy} !== {1'b0, xb}) begin
                n_fail++;
                $display("FAIL rst_mid stall_busy c=%0d: got %b expected %b", c, {o_stall, o_busy}, {1'b0, xb});
            end
            sb.push_back(exp);
            tick();
            got = {o_ce, o_val, o_opc, o_rd};
            exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rst_mid out c=%0d: got %h expected %h", c, got, exp);
            end
        end
        model_hi = '0;
        model_lo = '0;
    endtask

    initial begin
        logic [DW-1:0] ra, rb, rh, rl;
        logic [2:0]    ro;
        rst = 1'b1;
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0, 32'h0, 6'h0, 5'd0);
        test_reset();
        test_alu_path();
        test_mdu_op(MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
        test_mdu_op(DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, "divu_100_7");
        test_mdu_op(DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        test_mdu_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, "div_min_m1");
        test_mdu_op(DIV,   32'd9,         32'd0,        32'h0000_0009, 32'hFFFF_FFFF, "div_9_0");
        test_mdu_op(DIVU,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, "divu_by0");
        test_mdu_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
        test_mdu_op(MULTU, 32'd7,         32'd1,        32'h0,         32'h0000_0007, "multu_7x1");
        test_mdu_op(MULT,  32'h0001_2345, 32'd0,        32'h0,         32'h0,         "mult_x0");
        test_mdu_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        test_mdu_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        "mult_min_min");
        for (int i = 0; i < 4; i++) begin
            ro = 3'(i + 1);
            ra = $urandom;
            rb = $urandom;
            if (rb == 0) rb = 32'd3;
            ref_mdu(ro, ra, rb, rh, rl);
            test_mdu_op(ro, ra, rb, rh, rl, "random");
        end
        test_busy_passthrough();
        test_flush_no_start();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
